// File: rtl/fractal_sync_node.sv
// rtl/fractal_sync_node.sv - binary node of the fractal synchronization tree
// Optional barrier statistics counter: FSYNC_NODE_STATS_EN
module fractal_sync_node #(
  parameter int LVL_WIDTH = 4,
  parameter int NODE_LVL  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             ch_req_i,
  input  logic [2*LVL_WIDTH-1:0] ch_lvl_i,
  output logic [1:0]             ch_ack_o,
  output logic [1:0]             ch_err_o,
  output logic                   par_req_o,
  output logic [LVL_WIDTH-1:0]   par_lvl_o,
  input  logic                   par_ack_i,
  input  logic                   par_err_i,
  output logic                   busy_o,
  output logic [15:0]            sync_cnt_o
);

  localparam logic [LVL_WIDTH-1:0] MY_LVL = LVL_WIDTH'(NODE_LVL);

  typedef enum logic [1:0] {IDLE, HALF, WAIT_PAR} state_t;

  state_t                 state, state_d;
  logic                   pend_id, pend_id_d;
  logic [LVL_WIDTH-1:0]   pend_lvl, pend_lvl_d;

  logic [LVL_WIDTH-1:0]   lvl0, lvl1, lvl_other;
  logic                   v0, v1, v_other, req_other, other_id;

  // pair resolution operands, shared by the IDLE and HALF paths
  logic                   do_resolve;
  logic [LVL_WIDTH-1:0]   res_a, res_b;
  logic                   local_done, relay_done;

  logic [1:0]             ack_d, err_d;
  logic                   preq_d;
  logic [LVL_WIDTH-1:0]   plvl_d;

  assign lvl0      = ch_lvl_i[LVL_WIDTH-1:0];
  assign lvl1      = ch_lvl_i[2*LVL_WIDTH-1:LVL_WIDTH];
  assign v0        = ch_req_i[0] && (lvl0 >= MY_LVL);
  assign v1        = ch_req_i[1] && (lvl1 >= MY_LVL);
  assign other_id  = ~pend_id;
  assign req_other = other_id ? ch_req_i[1] : ch_req_i[0];
  assign lvl_other = other_id ? lvl1 : lvl0;
  assign v_other   = other_id ? v1 : v0;

  // next-state and registered-output decode
  always_comb begin
    state_d    = state;
    pend_id_d  = pend_id;
    pend_lvl_d = pend_lvl;
    ack_d      = 2'b00;
    err_d      = 2'b00;
    preq_d     = 1'b0;
    plvl_d     = par_lvl_o;
    do_resolve = 1'b0;
    res_a      = '0;
    res_b      = '0;
    local_done = 1'b0;
    relay_done = 1'b0;

    case (state)
      IDLE: begin
        if (v0 && v1) begin
          do_resolve = 1'b1;
          res_a      = lvl0;
          res_b      = lvl1;
        end else begin
          if (ch_req_i[0] && !v0) err_d[0] = 1'b1;
          if (ch_req_i[1] && !v1) err_d[1] = 1'b1;
          if (v0) begin
            pend_id_d  = 1'b0;
            pend_lvl_d = lvl0;
            state_d    = HALF;
          end else if (v1) begin
            pend_id_d  = 1'b1;
            pend_lvl_d = lvl1;
            state_d    = HALF;
          end
        end
      end
      HALF: begin
        // a second pulse from the pending child never replaces its request
        if (pend_id ? ch_req_i[1] : ch_req_i[0]) err_d[pend_id] = 1'b1;
        if (req_other && !v_other) begin
          err_d[other_id] = 1'b1;
        end else if (v_other) begin
          do_resolve = 1'b1;
          res_a      = pend_lvl;
          res_b      = lvl_other;
        end
      end
      WAIT_PAR: begin
        err_d = ch_req_i;
        if (par_err_i) begin
          err_d   = 2'b11;
          state_d = IDLE;
        end else if (par_ack_i) begin
          ack_d      = 2'b11;
          relay_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_resolve) begin
      if (res_a != res_b) begin
        err_d   = 2'b11;
        state_d = IDLE;
      end else if (res_a == MY_LVL) begin
        ack_d      = 2'b11;
        local_done = 1'b1;
        state_d    = IDLE;
      end else begin
        preq_d  = 1'b1;
        plvl_d  = res_a;
        state_d = WAIT_PAR;
      end
    end

    // a child never sees ack and err together; err takes precedence
    ack_d = ack_d & ~err_d;
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      pend_id   <= 1'b0;
      pend_lvl  <= '0;
      ch_ack_o  <= 2'b00;
      ch_err_o  <= 2'b00;
      par_req_o <= 1'b0;
      par_lvl_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_d;
      pend_id   <= pend_id_d;
      pend_lvl  <= pend_lvl_d;
      ch_ack_o  <= ack_d;
      ch_err_o  <= err_d;
      par_req_o <= preq_d;
      par_lvl_o <= plvl_d;
      busy_o    <= (state_d != IDLE);
    end
  end

`ifdef FSYNC_NODE_STATS_EN
  logic [15:0] sync_cnt;

  // saturating count of successful barriers, updated alongside the ack pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_cnt <= 16'h0000;
    end else if ((local_done || relay_done) && (sync_cnt != 16'hFFFF)) begin
      sync_cnt <= sync_cnt + 16'h0001;
    end
  end

  assign sync_cnt_o = sync_cnt;
`else
  assign sync_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fractal_sync_node.sv
// tb/tb_fractal_sync_node.sv - scoreboard bench for fractal_sync_node
module tb_fractal_sync_node;

  typedef struct {
    int         cyc;
    logic [1:0] ack;
    logic [1:0] err;
    logic       preq;
    logic [3:0] plvl;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int exp_cnt[2];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]  a_req, b_req;
  logic [7:0]  a_lvl, b_lvl;
  logic        a_pack, a_perr, b_pack, b_perr;
  logic [1:0]  a_ack, a_err, b_ack, b_err;
  logic        a_preq, b_preq, a_busy, b_busy;
  logic [3:0]  a_plvl, b_plvl;
  logic [15:0] a_cnt, b_cnt;

  fractal_sync_node #(.LVL_WIDTH(4), .NODE_LVL(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .ch_req_i(a_req), .ch_lvl_i(a_lvl),
    .ch_ack_o(a_ack), .ch_err_o(a_err), .par_req_o(a_preq), .par_lvl_o(a_plvl),
    .par_ack_i(a_pack), .par_err_i(a_perr), .busy_o(a_busy), .sync_cnt_o(a_cnt)
  );

  fractal_sync_node #(.LVL_WIDTH(4), .NODE_LVL(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .ch_req_i(b_req), .ch_lvl_i(b_lvl),
    .ch_ack_o(b_ack), .ch_err_o(b_err), .par_req_o(b_preq), .par_lvl_o(b_plvl),
    .par_ack_i(b_pack), .par_err_i(b_perr), .busy_o(b_busy), .sync_cnt_o(b_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    vectors++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qhead(input int d);
    if (d == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic expect_rsp(input int d, input logic [1:0] ak, input logic [1:0] er,
                            input logic pr = 1'b0, input logic [3:0] pl = 4'd0);
    exp_t e;
    e.cyc = cyc + 1; e.ack = ak; e.err = er; e.preq = pr; e.plvl = pl;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic bump(input int d);
`ifdef FSYNC_NODE_STATS_EN
    if (exp_cnt[d] < 65535) exp_cnt[d]++;
`else
    exp_cnt[d] = 0;
`endif
  endtask

  task automatic drv(input int d, input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                     input logic pa = 1'b0, input logic pe = 1'b0);
    @(posedge clk); #1;
    a_req = 2'b00; a_lvl = 8'h00; a_pack = 1'b0; a_perr = 1'b0;
    b_req = 2'b00; b_lvl = 8'h00; b_pack = 1'b0; b_perr = 1'b0;
    if (d == 0) begin
      a_req = r; a_lvl = {l1, l0}; a_pack = pa; a_perr = pe;
    end else begin
      b_req = r; b_lvl = {l1, l0}; b_pack = pa; b_perr = pe;
    end
  endtask

  task automatic idle();
    drv(0, 2'b00, 4'd0, 4'd0);
  endtask

  // compares one DUT's response pulses against its expectation queue
  task automatic mon(input int d);
    logic [1:0] k, er;
    logic       pr;
    logic [3:0] pl;
    exp_t       e;
    k  = (d == 0) ? a_ack : b_ack;
    er = (d == 0) ? a_err : b_err;
    pr = (d == 0) ? a_preq : b_preq;
    pl = (d == 0) ? a_plvl : b_plvl;
    while (qsize(d) > 0 && qhead(d).cyc < cyc) begin
      e = qhead(d);
      vectors++; fails++;
      $display("FAIL missing_rsp dut%0d: nothing at cycle %0d, expected ack=%b err=%b preq=%b",
               d, e.cyc, e.ack, e.err, e.preq);
      qpop(d);
    end
    if (k != 2'b00 || er != 2'b00 || pr) begin
      vectors++;
      if (qsize(d) == 0 || qhead(d).cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_rsp dut%0d cycle %0d: got ack=%b err=%b preq=%b, expected none",
                 d, cyc, k, er, pr);
      end else begin
        e = qhead(d);
        qpop(d);
        if (k !== e.ack || er !== e.err || pr !== e.preq || (e.preq && pl !== e.plvl)) begin
          fails++;
          $display("FAIL rsp dut%0d cycle %0d: got ack=%b err=%b preq=%b lvl=%0d, expected ack=%b err=%b preq=%b lvl=%0d",
                   d, cyc, k, er, pr, pl, e.ack, e.err, e.preq, e.plvl);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic chk_a_zero(input string nm);
    chk({nm, "_ack"}, a_ack, 0);
    chk({nm, "_err"}, a_err, 0);
    chk({nm, "_preq"}, a_preq, 0);
    chk({nm, "_plvl"}, a_plvl, 0);
    chk({nm, "_busy"}, a_busy, 0);
    chk({nm, "_cnt"}, a_cnt, 0);
  endtask

  initial begin
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    a_req = 2'b00; a_lvl = 8'h00; a_pack = 1'b0; a_perr = 1'b0;
    b_req = 2'b00; b_lvl = 8'h00; b_pack = 1'b0; b_perr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_a_zero("reset");
    chk("reset_b_busy", b_busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // simultaneous local barrier
    drv(0, 2'b11, 4'd1, 4'd1); expect_rsp(0, 2'b11, 2'b00); bump(0);
    idle(); @(negedge clk);
    chk("local_busy", a_busy, 0);
    chk("local_cnt", a_cnt, exp_cnt[0]);

    // staggered forward to parent, parent ack four cycles later
    drv(0, 2'b01, 4'd2, 4'd0);
    idle(); @(negedge clk);
    chk("half_busy", a_busy, 1);
    idle();
    drv(0, 2'b10, 4'd0, 4'd2); expect_rsp(0, 2'b00, 2'b00, 1'b1, 4'd2);
    idle(); @(negedge clk);
    chk("wait_busy", a_busy, 1);
    idle();
    idle();
    drv(0, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0); expect_rsp(0, 2'b11, 2'b00); bump(0);
    idle(); @(negedge clk);
    chk("relay_busy", a_busy, 0);
    chk("plvl_hold", a_plvl, 2);
    chk("relay_cnt", a_cnt, exp_cnt[0]);

    // unequal levels
    drv(0, 2'b01, 4'd1, 4'd0);
    drv(0, 2'b10, 4'd0, 4'd2); expect_rsp(0, 2'b00, 2'b11);
    idle(); @(negedge clk);
    chk("unequal_busy", a_busy, 0);

    // back-to-back local barriers, then a forward with a busy pulse and ack+err from parent
    for (int i = 0; i < 3; i++) begin
      drv(0, 2'b11, 4'd1, 4'd1); expect_rsp(0, 2'b11, 2'b00); bump(0);
    end
    drv(0, 2'b11, 4'd2, 4'd2); expect_rsp(0, 2'b00, 2'b00, 1'b1, 4'd2);
    drv(0, 2'b01, 4'd1, 4'd0); expect_rsp(0, 2'b00, 2'b01);
    drv(0, 2'b00, 4'd0, 4'd0, 1'b1, 1'b1); expect_rsp(0, 2'b00, 2'b11);
    idle(); @(negedge clk);
    chk("ackerr_busy", a_busy, 0);
    chk("ackerr_cnt", a_cnt, exp_cnt[0]);

    // invalid requests in IDLE
    drv(0, 2'b10, 4'd0, 4'd0); expect_rsp(0, 2'b00, 2'b10);
    drv(0, 2'b11, 4'd0, 4'd0); expect_rsp(0, 2'b00, 2'b11);
    drv(0, 2'b11, 4'd1, 4'd0); expect_rsp(0, 2'b00, 2'b10);
    idle(); @(negedge clk);
    chk("mixed_busy", a_busy, 1);
    drv(0, 2'b10, 4'd0, 4'd1); expect_rsp(0, 2'b11, 2'b00); bump(0);

    // parent error alone
    drv(0, 2'b11, 4'd3, 4'd3); expect_rsp(0, 2'b00, 2'b00, 1'b1, 4'd3);
    idle();
    drv(0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b1); expect_rsp(0, 2'b00, 2'b11);
    idle(); @(negedge clk);
    chk("parerr_busy", a_busy, 0);
    chk("parerr_plvl", a_plvl, 3);

    // reset while in HALF drops the pending request
    drv(0, 2'b01, 4'd1, 4'd0);
    idle(); @(negedge clk);
    chk("prerst_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_a_zero("midrst");
    exp_cnt[0] = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    drv(0, 2'b10, 4'd0, 4'd1);
    idle(); @(negedge clk);
    chk("postrst_busy", a_busy, 1);
    drv(0, 2'b10, 4'd0, 4'd1); expect_rsp(0, 2'b00, 2'b10);
    drv(0, 2'b01, 4'd1, 4'd0); expect_rsp(0, 2'b11, 2'b00); bump(0);

    // node at level 2
    drv(1, 2'b10, 4'd0, 4'd1); expect_rsp(1, 2'b00, 2'b10);
    idle(); @(negedge clk);
    chk("b_nolatch_busy", b_busy, 0);
    drv(1, 2'b01, 4'd2, 4'd0);
    drv(1, 2'b01, 4'd2, 4'd0); expect_rsp(1, 2'b00, 2'b01);
    drv(1, 2'b10, 4'd0, 4'd1); expect_rsp(1, 2'b00, 2'b10);
    idle(); @(negedge clk);
    chk("b_half_busy", b_busy, 1);
    drv(1, 2'b10, 4'd0, 4'd2); expect_rsp(1, 2'b11, 2'b00); bump(1);
    idle(); @(negedge clk);
    chk("b_busy_done", b_busy, 0);
    chk("b_cnt", b_cnt, exp_cnt[1]);

    // counter saturation or absence
`ifdef FSYNC_NODE_STATS_EN
    for (int i = 0; i < 65537; i++) begin
      drv(0, 2'b11, 4'd1, 4'd1); expect_rsp(0, 2'b11, 2'b00); bump(0);
    end
    idle(); @(negedge clk);
    chk("sat_cnt", a_cnt, 16'hFFFF);
    chk("sat_model", a_cnt, exp_cnt[0]);
`else
    for (int i = 0; i < 5; i++) begin
      drv(0, 2'b11, 4'd1, 4'd1); expect_rsp(0, 2'b11, 2'b00); bump(0);
    end
    idle(); @(negedge clk);
    chk("nostats_cnt", a_cnt, 0);
`endif

    repeat (3) idle();
    @(negedge clk);
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
